score_rate_counter: RTL and testbench

Parametrised successor to the game's timed score accumulator. While enabled, it adds STEP to a WIDTH-bit score once every PERIOD enabled cycles, starting on the first enabled cycle. It also accepts single-cycle bonus additions, saturates at the maximum value, and can either clear or freeze when disabled. It sits between the game FSM (which drives en and bonus) and the score/high-score display path.

---
 rtl/score_rate_counter.sv | 91 +++++++++
 tb/tb_score_rate_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_rate_counter.sv
// Timed score accumulator: adds STEP every PERIOD enabled cycles, plus bonus, saturating at MAX.
// Optional best-score register built when SCORE_HISCORE_EN is defined; otherwise hiscore is 0.
module score_rate_counter #(
   parameter int WIDTH        = 32,
   parameter int PERIOD       = 30,
   parameter int STEP         = 100000,
   parameter int CLEAR_ON_DIS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             bonus_vld,
   input  logic [WIDTH-1:0] bonus_amt,
   output logic [WIDTH-1:0] value,
   output logic             tick,
   output logic             sat,
   output logic [WIDTH-1:0] hiscore
);

   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PW-1:0]    LAST   = PW'(PERIOD - 1);
   localparam logic [WIDTH+1:0] STEP_W = (WIDTH + 2)'(STEP);
   localparam logic [WIDTH+1:0] MAXV   = {2'b00, {WIDTH{1'b1}}};

   logic [PW-1:0]    phase;
   logic [PW-1:0]    phase_nxt;
   logic [WIDTH+1:0] sum;
   logic [WIDTH-1:0] value_nxt;
   logic             sat_nxt;
   logic             tick_nxt;
   logic             wipe;

   assign wipe = clr || (!en && (CLEAR_ON_DIS != 0));

   // Two guard bits on the sum so value + STEP + bonus can never wrap before the clip test.
   always_comb begin
      sum       = {2'b00, value}
                + ((phase == '0) ? STEP_W : '0)
                + (bonus_vld ? {2'b00, bonus_amt} : '0);
      phase_nxt = phase;
      value_nxt = value;
      sat_nxt   = sat;
      tick_nxt  = 1'b0;
      if (wipe) begin
         phase_nxt = '0;
         value_nxt = '0;
         sat_nxt   = 1'b0;
      end else if (en) begin
         tick_nxt  = (phase == '0);
         phase_nxt = (phase == LAST) ? '0 : phase + 1'b1;
         if (sum > MAXV) begin
            value_nxt = '1;
            sat_nxt   = 1'b1;
         end else begin
            value_nxt = sum[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= '0;
         value <= '0;
         sat   <= 1'b0;
         tick  <= 1'b0;
      end else begin
         phase <= phase_nxt;
         value <= value_nxt;
         sat   <= sat_nxt;
         tick  <= tick_nxt;
      end
   end

`ifdef SCORE_HISCORE_EN
   // Survives clr and disable so the best score outlives a game restart.
   logic [WIDTH-1:0] hi_q;

   always_ff @(posedge clk) begin
      if (rst)
         hi_q <= '0;
      else if (value_nxt > hi_q)
         hi_q <= value_nxt;
   end

   assign hiscore = hi_q;
`else
   assign hiscore = '0;
`endif

endmodule

// File: tb/tb_score_rate_counter.sv
// Directed bench for score_rate_counter: default instance, freeze-on-disable instance, 8-bit saturating instance.
module tb_score_rate_counter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        en0, clr0, bv0, t0, s0;
   logic [31:0] ba0, v0, h0;
   logic        en1, clr1, bv1, t1, s1;
   logic [31:0] ba1, v1, h1;
   logic        en2, clr2, bv2, t2, s2;
   logic [7:0]  ba2, v2, h2;

   int total = 0;
   int bad   = 0;

   score_rate_counter u0 (
      .clk(clk), .rst(rst), .en(en0), .clr(clr0), .bonus_vld(bv0), .bonus_amt(ba0),
      .value(v0), .tick(t0), .sat(s0), .hiscore(h0));

   score_rate_counter #(.CLEAR_ON_DIS(0)) u1 (
      .clk(clk), .rst(rst), .en(en1), .clr(clr1), .bonus_vld(bv1), .bonus_amt(ba1),
      .value(v1), .tick(t1), .sat(s1), .hiscore(h1));

   score_rate_counter #(.WIDTH(8), .PERIOD(2), .STEP(100)) u2 (
      .clk(clk), .rst(rst), .en(en2), .clr(clr2), .bonus_vld(bv2), .bonus_amt(ba2),
      .value(v2), .tick(t2), .sat(s2), .hiscore(h2));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en0 = 0; clr0 = 0; bv0 = 0; ba0 = '0;
      en1 = 0; clr1 = 0; bv1 = 0; ba1 = '0;
      en2 = 0; clr2 = 0; bv2 = 0; ba2 = '0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({v0, t0, s0, h0} !== 66'd0) begin
         bad++; $display("FAIL reset_u0 value=%0d tick=%b sat=%b hi=%0d want all 0", v0, t0, s0, h0);
      end
      total++;
      if ({v1, t1, s1, v2, t2, s2, h2} !== 52'd0) begin
         bad++; $display("FAIL reset_u1u2 v1=%0d v2=%0d t2=%b s2=%b h2=%0d want all 0", v1, v2, t2, s2, h2);
      end
   endtask

   task automatic test_timed();
      int exp_v;
      logic exp_t;
      do_reset();
      en0 = 1;
      for (int k = 1; k <= 61; k++) begin
         cyc();
         exp_v = 100000 * ((k - 1) / 30 + 1);
         exp_t = ((k - 1) % 30 == 0);
         total++;
         if (v0 !== 32'(exp_v) || t0 !== exp_t) begin
            bad++; $display("FAIL timed_edge%0d value=%0d tick=%b want %0d %b", k, v0, t0, exp_v, exp_t);
         end
      end
   endtask

   task automatic test_disable_clear();
      do_reset();
      en0 = 1;
      repeat (45) cyc();
      total++;
      if (v0 !== 32'd200000) begin
         bad++; $display("FAIL dis_pre value=%0d want 200000", v0);
      end
      en0 = 0;
      cyc();
      total++;
      if (v0 !== 32'd0 || s0 !== 1'b0 || t0 !== 1'b0) begin
         bad++; $display("FAIL dis_clear value=%0d sat=%b tick=%b want 0 0 0", v0, s0, t0);
      end
      en0 = 1;
      cyc();
      total++;
      if (v0 !== 32'd100000 || t0 !== 1'b1) begin
         bad++; $display("FAIL dis_reenable value=%0d tick=%b want 100000 1", v0, t0);
      end
   endtask

   task automatic test_freeze();
      do_reset();
      en1 = 1;
      repeat (45) cyc();
      total++;
      if (v1 !== 32'd200000) begin
         bad++; $display("FAIL frz_pre value=%0d want 200000", v1);
      end
      en1 = 0;
      bv1 = 1; ba1 = 32'd777;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         total++;
         if (v1 !== 32'd200000 || t1 !== 1'b0 || s1 !== 1'b0) begin
            bad++; $display("FAIL frz_hold%0d value=%0d tick=%b want 200000 0", k, v1, t1);
         end
      end
      bv1 = 0;
      en1 = 1;
      repeat (15) cyc();
      total++;
      if (v1 !== 32'd200000 || t1 !== 1'b0) begin
         bad++; $display("FAIL frz_resume15 value=%0d tick=%b want 200000 0", v1, t1);
      end
      cyc();
      total++;
      if (v1 !== 32'd300000 || t1 !== 1'b1) begin
         bad++; $display("FAIL frz_resume16 value=%0d tick=%b want 300000 1", v1, t1);
      end
   endtask

   task automatic test_bonus();
      do_reset();
      en0 = 1;
      repeat (30) cyc();
      bv0 = 1; ba0 = 32'd5000;
      cyc();
      total++;
      if (v0 !== 32'd205000 || t0 !== 1'b1) begin
         bad++; $display("FAIL bonus_tick value=%0d tick=%b want 205000 1", v0, t0);
      end
      ba0 = 32'd7;
      cyc();
      total++;
      if (v0 !== 32'd205007 || t0 !== 1'b0) begin
         bad++; $display("FAIL bonus_only value=%0d tick=%b want 205007 0", v0, t0);
      end
      clr0 = 1;
      cyc();
      total++;
      if (v0 !== 32'd0) begin
         bad++; $display("FAIL bonus_clr value=%0d want 0", v0);
      end
      clr0 = 0; en0 = 0;
      cyc();
      total++;
      if (v0 !== 32'd0) begin
         bad++; $display("FAIL bonus_dis value=%0d want 0", v0);
      end
      bv0 = 0; en0 = 1;
      cyc();
      total++;
      if (v0 !== 32'd100000) begin
         bad++; $display("FAIL bonus_after_dis value=%0d want 100000", v0);
      end
   endtask

   task automatic test_saturate();
      logic [7:0] exp_v [1:7];
      logic       exp_s [1:7];
      exp_v = '{8'd100, 8'd100, 8'd200, 8'd200, 8'd255, 8'd255, 8'd255};
      exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      en2 = 1;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         total++;
         if (v2 !== exp_v[k] || s2 !== exp_s[k] || t2 !== k[0]) begin
            bad++; $display("FAIL sat_edge%0d value=%0d sat=%b tick=%b want %0d %b %b",
                            k, v2, s2, t2, exp_v[k], exp_s[k], k[0]);
         end
      end
      clr2 = 1;
      cyc();
      total++;
      if (v2 !== 8'd0 || s2 !== 1'b0 || t2 !== 1'b0) begin
         bad++; $display("FAIL sat_clr value=%0d sat=%b tick=%b want 0 0 0", v2, s2, t2);
      end
      clr2 = 0;
      cyc();
      total++;
      if (v2 !== 8'd100 || t2 !== 1'b1) begin
         bad++; $display("FAIL sat_after_clr value=%0d tick=%b want 100 1", v2, t2);
      end
      cyc();
      rst = 1; clr2 = 1;
      cyc();
      total++;
      if (v2 !== 8'd0 || s2 !== 1'b0 || t2 !== 1'b0 || h2 !== 8'd0) begin
         bad++; $display("FAIL sat_rstclr value=%0d sat=%b tick=%b hi=%0d want 0 0 0 0", v2, s2, t2, h2);
      end
      rst = 0; clr2 = 0;
      bv2 = 1; ba2 = 8'd255;
      cyc();
      total++;
      if (v2 !== 8'd255 || s2 !== 1'b1 || t2 !== 1'b1) begin
         bad++; $display("FAIL sat_bonus_wrap value=%0d sat=%b tick=%b want 255 1 1", v2, s2, t2);
      end
      bv2 = 0;
   endtask

   task automatic test_hiscore();
      logic [31:0] exp_hi;
      do_reset();
      en0 = 1;
      repeat (61) cyc();
      en0 = 0;
      cyc();
`ifdef SCORE_HISCORE_EN
      exp_hi = 32'd300000;
`else
      exp_hi = 32'd0;
`endif
      total++;
      if (v0 !== 32'd0 || h0 !== exp_hi) begin
         bad++; $display("FAIL hi_after_dis value=%0d hi=%0d want 0 %0d", v0, h0, exp_hi);
      end
      en0 = 1;
      cyc();
      total++;
      if (v0 !== 32'd100000 || h0 !== exp_hi) begin
         bad++; $display("FAIL hi_keep value=%0d hi=%0d want 100000 %0d", v0, h0, exp_hi);
      end
      do_reset();
      total++;
      if (h0 !== 32'd0) begin
         bad++; $display("FAIL hi_rst hi=%0d want 0", h0);
      end
   endtask

   initial begin
      test_reset();
      test_timed();
      test_disable_clear();
      test_freeze();
      test_bonus();
      test_saturate();
      test_hiscore();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
